// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC generation, one-cycle imem fetch and one-entry hold for buffer backpressure
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        buf_full,
    output logic        enq,
    output logic [31:0] enq_data,
    output logic        flush_out,
    output logic [31:0] fetch_pc
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} mode_t;

    mode_t       mode, mode_nxt;
    logic [31:0] pc, pc_nxt;
    logic        inflight, inflight_nxt;
    logic [31:0] inflight_pc, inflight_pc_nxt;
    logic [31:0] hold_data, hold_data_nxt;
    logic [31:0] hold_pc, hold_pc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode        <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            hold_data   <= 32'h0;
            hold_pc     <= RESET_PC;
        end else begin
            mode        <= mode_nxt;
            pc          <= pc_nxt;
            inflight    <= inflight_nxt;
            inflight_pc <= inflight_pc_nxt;
            hold_data   <= hold_data_nxt;
            hold_pc     <= hold_pc_nxt;
        end
    end

    // Stalling issue whenever an in-flight word cannot drain keeps at most one word unaccepted.
    assign imem_req  = !reset && !flush && !halt && (mode == RUN) && !(inflight && buf_full);
    assign imem_addr = pc;
    assign flush_out = flush && !reset;

    always_comb begin
        mode_nxt        = mode;
        pc_nxt          = pc;
        inflight_nxt    = 1'b0;
        inflight_pc_nxt = inflight_pc;
        hold_data_nxt   = hold_data;
        hold_pc_nxt     = hold_pc;
        enq             = 1'b0;
        enq_data        = hold_data;
        fetch_pc        = hold_pc;

        if (mode == RUN && inflight) begin
            enq_data = imem_rdata;
            fetch_pc = inflight_pc;
        end

        if (flush) begin
            mode_nxt = RUN;
            pc_nxt   = redirect_pc;
        end else begin
            if (imem_req) begin
                pc_nxt          = pc + PC_STEP;
                inflight_nxt    = 1'b1;
                inflight_pc_nxt = pc;
            end
            case (mode)
                HOLD: begin
                    enq = !buf_full;
                    if (!buf_full) mode_nxt = RUN;
                end
                default: begin
                    if (inflight) begin
                        enq = !buf_full;
                        if (buf_full) begin
                            mode_nxt      = HOLD;
                            hold_data_nxt = imem_rdata;
                            hold_pc_nxt   = inflight_pc;
                        end
                    end
                end
            endcase
        end

        if (reset) enq = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(mode == HOLD && inflight));
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset, flush, halt, buf_full;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        enq;
    logic [31:0] enq_data;
    logic        flush_out;
    logic [31:0] fetch_pc;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .redirect_pc(redirect_pc), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .buf_full(buf_full), .enq(enq), .enq_data(enq_data), .flush_out(flush_out),
        .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word = address ^ KEY, one cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
    end

    typedef struct {
        logic        rst;
        logic        fl;
        logic        ht;
        logic        bf;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_enq;
        logic [31:0] e_pc;
        logic        e_fo;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic h, input logic b,
                         input logic [31:0] rpc);
        reset = r; flush = f; halt = h; buf_full = b; redirect_pc = rpc;
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_enq, input logic [31:0] e_pc, input logic e_fo);
        @(negedge clk);
        chk({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, e_req});
        chk({tag, " imem_addr"}, imem_addr, e_addr);
        chk({tag, " enq"}, {31'h0, enq}, {31'h0, e_enq});
        chk({tag, " flush_out"}, {31'h0, flush_out}, {31'h0, e_fo});
        if (e_enq) begin
            chk({tag, " fetch_pc"}, fetch_pc, e_pc);
            chk({tag, " enq_data"}, enq_data, e_pc ^ KEY);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst   fl    ht    bf    rpc           req   addr          enq   fetch_pc      fo
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0,       1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h4,       1'b1, 32'h0,       1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,       1'b0, 32'h8,       1'b0, 32'h0,       1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,       1'b0, 32'h8,       1'b0, 32'h0,       1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,       1'b0, 32'h8,       1'b0, 32'h0,       1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h8,       1'b1, 32'h4,       1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h8,       1'b0, 32'h0,       1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hC,       1'b1, 32'h8,       1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h100,     1'b0, 32'h10,      1'b0, 32'h0,       1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,     1'b0, 32'h0,       1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h104,     1'b1, 32'h100,     1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,       1'b0, 32'h108,     1'b0, 32'h0,       1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h100,     1'b0, 32'h108,     1'b0, 32'h0,       1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,     1'b0, 32'h0,       1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h104,     1'b1, 32'h100,     1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h108,     1'b1, 32'h104,     1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h108,     1'b0, 32'h0,       1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h108,     1'b0, 32'h0,       1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h108,     1'b0, 32'h0,       1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h108,     1'b0, 32'h0,       1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h10C,     1'b1, 32'h108,     1'b0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].ht, vecs[i].bf, vecs[i].rpc);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_enq, vecs[i].e_pc, vecs[i].e_fo);
        end

        // Reset wins over a simultaneous flush, and clears the word still in flight.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
        check_outputs("rst_flush", 1'b0, 32'h110, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_outputs("post_rst", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

        // Reset while holding a word: nothing enqueues then or afterwards.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check_outputs("hold_fill", 1'b0, 32'h4, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_outputs("rst_in_hold", 1'b0, 32'h4, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_outputs("hold_cleared", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

        // PC wrap at the top of the address space.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        check_outputs("wrap_flush", 1'b0, 32'h4, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_outputs("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        check_outputs("wrap_zero", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        check_outputs("wrap_next", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
